apb_rr_master: RTL

Round-robin APB master that shares one APB completer (e.g. the register/memory slave) between N_REQ local requesters. Each requester presents a simple request bundle; the block arbitrates, drives the APB SETUP/ACCESS sequence, and returns read data and a completion strobe to the winner. A wait-state watchdog aborts transfers whose completer never asserts pready.

---
 rtl/apb_rr_master.sv | 132 +++++++++++++
 1 files changed

// File: rtl/apb_rr_master.sv
// Round-robin APB master: arbitrates N_REQ local requesters onto one APB completer,
// with a wait-state watchdog that aborts transfers stuck with pready low.
module apb_rr_master #(
  parameter int N_REQ   = 4,
  parameter int ADDR_BW = 8,
  parameter int DATA_BW = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           req_write,
  input  logic [N_REQ*ADDR_BW-1:0]   req_addr,
  input  logic [N_REQ*DATA_BW-1:0]   req_wdata,
  output logic [N_REQ-1:0]           done,
  output logic                       err,
  output logic [DATA_BW-1:0]         rdata,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [ADDR_BW-1:0]         paddr,
  output logic [DATA_BW-1:0]         pwdata,
  input  logic [DATA_BW-1:0]         prdata,
  input  logic                       pready
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] owner, last_owner, winner;
  logic [CNT_W-1:0] wait_cnt;
  logic             grant, fin, abort;

  // Search begins just after the last owner, so the finishing owner is always lowest priority.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] k;
    logic             found;
    int               idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last) + i) % N_REQ;
      k   = IDX_W'(idx);
      if (!found && r[k]) begin
        pick  = k;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb winner = rr_pick(req, last_owner);

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    fin      = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant    = 1'b1;
          state_nx = SETUP;
        end
      end
      SETUP: state_nx = ACCESS;
      ACCESS: begin
        if (pready) begin
          fin = 1'b1;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          fin   = 1'b1;
          abort = 1'b1;
        end
        if (fin) begin
          if (|req) begin
            grant    = 1'b1;
            state_nx = SETUP;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    done = '0;
    if (fin) done[owner] = 1'b1;
    err   = abort;
    rdata = (fin && !abort) ? prdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // APB outputs are registered from the next-state decode and latched winner fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      owner      <= '0;
      last_owner <= IDX_W'(N_REQ - 1);
      wait_cnt   <= '0;
    end else begin
      psel    <= (state_nx != IDLE);
      penable <= (state_nx == ACCESS);
      if (grant) begin
        owner      <= winner;
        last_owner <= winner;
        pwrite     <= req_write[winner];
        paddr      <= req_addr[int'(winner)*ADDR_BW +: ADDR_BW];
        pwdata     <= req_wdata[int'(winner)*DATA_BW +: DATA_BW];
      end
      if (state == SETUP)
        wait_cnt <= '0;
      else if (state == ACCESS && !fin)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule
